// File: rtl/ps2_key_tx.sv
// Keyboard-side PS/2 transmitter. Expands one key event into its byte
// sequence (E0 prefix, F0 prefix, scan code) and sends each byte as an
// 11-bit frame on device-driven clock/data, followed by one idle bit period.
module ps2_key_tx #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic       clk,
    input  logic       i_sclr,
    input  logic       i_key_valid,
    output logic       o_key_ready,
    input  logic [7:0] i_key_code,
    input  logic       i_key_break,
    input  logic       i_key_ext,
    output logic       o_ps2_clk,
    output logic       o_ps2_data,
    output logic       o_busy,
    output logic       o_byte_en,
    output logic [7:0] o_byte
);

    localparam int unsigned CntW = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] HalfPrev = CntW'(CLK_DIV - 2);
    localparam logic [3:0] StopIdx = 4'd10;
    localparam logic [3:0] GapIdx  = 4'd11;

    typedef enum logic [1:0] {StIdle, StSendE0, StSendF0, StSendCode} state_e;

    state_e          state_q;
    logic [CntW-1:0] half_cnt_q;
    logic            low_half_q;   // 0: clock-high half, 1: clock-low half
    logic [3:0]      bit_idx_q;    // 0..10 frame bits, 11 = inter-byte gap
    logic [10:0]     shreg_q;      // bit 0 drives the data line directly
    logic [7:0]      cur_byte_q;
    logic [7:0]      code_q;
    logic            brk_q;
    logic            ready_q;
    logic            ps2_clk_q;
    logic            byte_en_q;
    logic [7:0]      byte_q;

    // Frame: stop, odd parity, data (LSB first on the wire), start.
    function automatic logic [10:0] frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    logic [7:0] load_byte;
    state_e     load_state;

    // Byte and sequencer state for the next slot to be loaded.
    always_comb begin
        load_byte  = code_q;
        load_state = StSendCode;
        unique case (state_q)
            StIdle: begin
                if (i_key_ext) begin
                    load_byte  = 8'hE0;
                    load_state = StSendE0;
                end else if (i_key_break) begin
                    load_byte  = 8'hF0;
                    load_state = StSendF0;
                end else begin
                    load_byte  = i_key_code;
                    load_state = StSendCode;
                end
            end
            StSendE0: begin
                if (brk_q) begin
                    load_byte  = 8'hF0;
                    load_state = StSendF0;
                end
            end
            default: begin
                load_byte  = code_q;
                load_state = StSendCode;
            end
        endcase
    end

    // Sequencer, bit timing and registered line outputs.
    always_ff @(posedge clk or posedge i_sclr) begin
        if (i_sclr) begin
            state_q    <= StIdle;
            half_cnt_q <= '0;
            low_half_q <= 1'b0;
            bit_idx_q  <= '0;
            shreg_q    <= '1;
            cur_byte_q <= 8'h00;
            code_q     <= 8'h00;
            brk_q      <= 1'b0;
            ready_q    <= 1'b1;
            ps2_clk_q  <= 1'b1;
            byte_en_q  <= 1'b0;
            byte_q     <= 8'h00;
        end else begin
            byte_en_q <= 1'b0;
            if (state_q == StIdle) begin
                if (i_key_valid) begin
                    code_q     <= i_key_code;
                    brk_q      <= i_key_break;
                    ready_q    <= 1'b0;
                    state_q    <= load_state;
                    shreg_q    <= frame(load_byte);
                    cur_byte_q <= load_byte;
                    half_cnt_q <= '0;
                    low_half_q <= 1'b0;
                    bit_idx_q  <= '0;
                    ps2_clk_q  <= 1'b1;
                end
            end else if (half_cnt_q != HalfLast) begin
                half_cnt_q <= half_cnt_q + 1'b1;
                // Next cycle is the last one of the stop bit's low half.
                if (low_half_q && bit_idx_q == StopIdx && half_cnt_q == HalfPrev) begin
                    byte_en_q <= 1'b1;
                    byte_q    <= cur_byte_q;
                end
            end else if (!low_half_q) begin
                half_cnt_q <= '0;
                low_half_q <= 1'b1;
                // The gap period keeps the clock high throughout.
                ps2_clk_q  <= (bit_idx_q == GapIdx);
            end else if (bit_idx_q != GapIdx) begin
                half_cnt_q <= '0;
                low_half_q <= 1'b0;
                bit_idx_q  <= bit_idx_q + 1'b1;
                ps2_clk_q  <= 1'b1;
                shreg_q    <= {1'b1, shreg_q[10:1]};
            end else begin
                // Slot finished: load the next byte or return to idle.
                half_cnt_q <= '0;
                low_half_q <= 1'b0;
                bit_idx_q  <= '0;
                ps2_clk_q  <= 1'b1;
                if (state_q == StSendCode) begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end else begin
                    state_q    <= load_state;
                    shreg_q    <= frame(load_byte);
                    cur_byte_q <= load_byte;
                end
            end
        end
    end

    assign o_key_ready = ready_q;
    assign o_busy      = ~ready_q;
    assign o_ps2_clk   = ps2_clk_q;
    assign o_ps2_data  = shreg_q[0];
    assign o_byte_en   = byte_en_q;
    assign o_byte      = byte_q;

endmodule

// File: tb/tb_ps2_key_tx.sv
// Bench for ps2_key_tx: observes the PS/2 lines like a host would and
// compares bytes, frame bits and cycle timing against an event-level model.
module tb_ps2_key_tx;

    localparam int unsigned D = 4;
    localparam int SLOT = 24 * D;

    logic       clk = 1'b0;
    logic       i_sclr;
    logic       i_key_valid;
    logic [7:0] i_key_code;
    logic       i_key_break;
    logic       i_key_ext;
    logic       o_key_ready;
    logic       o_ps2_clk;
    logic       o_ps2_data;
    logic       o_busy;
    logic       o_byte_en;
    logic [7:0] o_byte;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Observations collected by the line monitor.
    int         fall_cyc[$];
    logic       fall_bit[$];
    int         en_cyc[$];
    logic [7:0] en_byte[$];
    int         low_cycles = 0;
    logic       prev_ps2_clk = 1'b1;

    // Expected byte sequence of the events under test.
    logic [7:0] exp_seq[$];

    ps2_key_tx #(.CLK_DIV(D)) dut (
        .clk        (clk),
        .i_sclr     (i_sclr),
        .i_key_valid(i_key_valid),
        .o_key_ready(o_key_ready),
        .i_key_code (i_key_code),
        .i_key_break(i_key_break),
        .i_key_ext  (i_key_ext),
        .o_ps2_clk  (o_ps2_clk),
        .o_ps2_data (o_ps2_data),
        .o_busy     (o_busy),
        .o_byte_en  (o_byte_en),
        .o_byte     (o_byte)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Host-side view: data sampled at each falling PS/2 clock.
    always @(negedge clk) begin
        if (prev_ps2_clk === 1'b1 && o_ps2_clk === 1'b0) begin
            fall_cyc.push_back(cyc);
            fall_bit.push_back(o_ps2_data);
        end
        if (o_ps2_clk !== 1'b1) low_cycles++;
        if (o_byte_en === 1'b1) begin
            en_cyc.push_back(cyc);
            en_byte.push_back(o_byte);
        end
        prev_ps2_clk = o_ps2_clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model: bit j of the line frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (j == 9) return (ones % 2 == 0);
        return 1'b1;
    endfunction

    // Model: byte sequence produced by one key event.
    function automatic void model_event(input logic [7:0] code, input logic brk,
                                        input logic ext);
        if (ext) exp_seq.push_back(8'hE0);
        if (brk) exp_seq.push_back(8'hF0);
        exp_seq.push_back(code);
    endfunction

    task automatic clear_mon();
        fall_cyc.delete();
        fall_bit.delete();
        en_cyc.delete();
        en_byte.delete();
        exp_seq.delete();
        low_cycles = 0;
    endtask

    // Present an event when ready; returns at the falling edge of cycle e,
    // the first cycle after the acceptance edge.
    task automatic accept_event(input logic [7:0] code, input logic brk, input logic ext,
                                input logic hold, output int e, output logic ok);
        int t = 0;
        @(negedge clk);
        while (o_key_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        ok = (o_key_ready === 1'b1);
        i_key_valid = 1'b1;
        i_key_code  = code;
        i_key_break = brk;
        i_key_ext   = ext;
        @(posedge clk);
        #1;
        e = cyc;
        @(negedge clk);
        if (!hold) i_key_valid = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output int r, output logic ok);
        int t = 0;
        while (o_key_ready !== 1'b1 && t < budget) begin
            @(negedge clk);
            t++;
        end
        r  = cyc;
        ok = (o_key_ready === 1'b1);
    endtask

    task automatic test_reset();
        i_sclr = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (o_ps2_clk !== 1'b1) begin errors++;
            $display("FAIL reset_ps2_clk: got %b expected 1", o_ps2_clk); end
        checks++; if (o_ps2_data !== 1'b1) begin errors++;
            $display("FAIL reset_ps2_data: got %b expected 1", o_ps2_data); end
        checks++; if (o_key_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready: got %b expected 1", o_key_ready); end
        checks++; if (o_busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b expected 0", o_busy); end
        checks++; if (o_byte_en !== 1'b0) begin errors++;
            $display("FAIL reset_byte_en: got %b expected 0", o_byte_en); end
        checks++; if (o_byte !== 8'h00) begin errors++;
            $display("FAIL reset_byte: got %h expected 00", o_byte); end
        i_sclr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_key_event(input logic [7:0] code, input logic brk, input logic ext);
        int e, r, n, nf;
        logic ok;
        clear_mon();
        model_event(code, brk, ext);
        n = exp_seq.size();
        accept_event(code, brk, ext, 1'b0, e, ok);
        checks++; if (!ok) begin errors++;
            $display("FAIL ev_accept_timeout: code %h never saw ready", code); end
        checks++;
        if (o_key_ready !== 1'b0 || o_busy !== 1'b1 || o_ps2_data !== 1'b0 ||
            o_ps2_clk !== 1'b1) begin
            errors++;
            $display("FAIL ev_first_cycle: ready %b busy %b data %b clk %b expected 0 1 0 1",
                     o_key_ready, o_busy, o_ps2_data, o_ps2_clk);
        end
        wait_ready(n * SLOT + 50, r, ok);
        checks++; if (!ok || r != e + n * SLOT) begin errors++;
            $display("FAIL ev_ready_rise: code %h got cycle %0d expected %0d", code, r - e,
                     n * SLOT); end
        nf = fall_cyc.size();
        checks++; if (nf != 11 * n) begin errors++;
            $display("FAIL ev_fall_count: got %0d expected %0d", nf, 11 * n); end
        if (nf > 11 * n) nf = 11 * n;
        for (int i = 0; i < nf; i++) begin
            logic eb;
            int   ec;
            eb = frame_bit(exp_seq[i / 11], i % 11);
            ec = e + (i / 11) * SLOT + (i % 11) * 2 * int'(D) + int'(D);
            checks++;
            if (fall_bit[i] !== eb || fall_cyc[i] != ec) begin
                errors++;
                $display("FAIL ev_frame_bit %0d: got bit %b at %0d expected bit %b at %0d",
                         i, fall_bit[i], fall_cyc[i] - e, eb, ec - e);
            end
        end
        checks++; if (en_cyc.size() != n) begin errors++;
            $display("FAIL ev_byte_en_count: got %0d expected %0d", en_cyc.size(), n); end
        for (int k = 0; k < n && k < en_cyc.size(); k++) begin
            checks++;
            if (en_byte[k] !== exp_seq[k] || en_cyc[k] != e + k * SLOT + 22 * int'(D) - 1) begin
                errors++;
                $display("FAIL ev_byte_en %0d: got %h at %0d expected %h at %0d", k,
                         en_byte[k], en_cyc[k] - e, exp_seq[k], k * SLOT + 22 * int'(D) - 1);
            end
        end
        checks++; if (low_cycles != 11 * n * int'(D)) begin errors++;
            $display("FAIL ev_clk_low_cycles: got %0d expected %0d", low_cycles,
                     11 * n * int'(D)); end
        checks++; if (o_byte !== code) begin errors++;
            $display("FAIL ev_last_byte: got %h expected %h", o_byte, code); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] x_code, y_code;
        logic       x_brk, x_ext, ok;
        int         e1, e2, r, r2, n1, t, nf;
        x_code = 8'($urandom);
        x_brk  = 1'($urandom);
        x_ext  = 1'($urandom);
        y_code = 8'($urandom);
        clear_mon();
        model_event(x_code, x_brk, x_ext);
        n1 = exp_seq.size();
        model_event(y_code, 1'b0, 1'b0);
        accept_event(x_code, x_brk, x_ext, 1'b1, e1, ok);
        checks++; if (!ok) begin errors++;
            $display("FAIL b2b_accept_timeout: first event never saw ready"); end
        // Churn the inputs while busy, then settle on the second event.
        t = 0;
        while (o_key_ready !== 1'b1 && t < 4 * SLOT) begin
            if (cyc < e1 + n1 * SLOT - 8) begin
                i_key_code  = 8'($urandom);
                i_key_break = 1'($urandom);
                i_key_ext   = 1'($urandom);
            end else begin
                i_key_code  = y_code;
                i_key_break = 1'b0;
                i_key_ext   = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        r = cyc;
        checks++; if (r != e1 + n1 * SLOT) begin errors++;
            $display("FAIL b2b_ready_rise: got %0d expected %0d", r - e1, n1 * SLOT); end
        checks++; if (o_ps2_clk !== 1'b1 || o_ps2_data !== 1'b1) begin errors++;
            $display("FAIL b2b_idle_lines: got clk %b data %b expected 1 1",
                     o_ps2_clk, o_ps2_data); end
        @(posedge clk);
        #1;
        e2 = cyc;
        @(negedge clk);
        i_key_valid = 1'b0;
        checks++; if (e2 != r + 1) begin errors++;
            $display("FAIL b2b_accept_edge: got %0d expected %0d", e2 - r, 1); end
        checks++; if (o_ps2_data !== 1'b0 || o_key_ready !== 1'b0) begin errors++;
            $display("FAIL b2b_start_bit: got data %b ready %b expected 0 0",
                     o_ps2_data, o_key_ready); end
        wait_ready(SLOT + 50, r2, ok);
        checks++; if (!ok || r2 != e2 + SLOT) begin errors++;
            $display("FAIL b2b_second_ready: got %0d expected %0d", r2 - e2, SLOT); end
        nf = fall_cyc.size();
        checks++; if (nf != 11 * (n1 + 1)) begin errors++;
            $display("FAIL b2b_fall_count: got %0d expected %0d", nf, 11 * (n1 + 1)); end
        if (nf == 11 * (n1 + 1)) begin
            checks++; if (fall_cyc[11 * n1] != e2 + int'(D)) begin errors++;
                $display("FAIL b2b_second_fall: got %0d expected %0d",
                         fall_cyc[11 * n1] - e2, D); end
            for (int k = 0; k <= n1; k++) begin
                logic [7:0] got;
                for (int j = 0; j < 8; j++) got[j] = fall_bit[11 * k + 1 + j];
                checks++; if (got !== exp_seq[k]) begin errors++;
                    $display("FAIL b2b_byte %0d: got %h expected %h", k, got, exp_seq[k]); end
            end
        end
        checks++; if (o_byte !== y_code) begin errors++;
            $display("FAIL b2b_last_byte: got %h expected %h", o_byte, y_code); end
    endtask

    task automatic test_reset_mid_frame();
        int   e;
        logic ok;
        clear_mon();
        accept_event(8'h74, 1'b1, 1'b1, 1'b0, e, ok);
        // Low half of bit 5 of the F0 frame.
        while (cyc < e + SLOT + 11 * int'(D) + 1) @(negedge clk);
        checks++; if (!ok || o_ps2_clk !== 1'b0) begin errors++;
            $display("FAIL rst_mid_pre_clk: got %b expected 0", o_ps2_clk); end
        i_sclr = 1'b1;
        #1;
        checks++; if (o_ps2_clk !== 1'b1 || o_ps2_data !== 1'b1) begin errors++;
            $display("FAIL rst_mid_lines: got clk %b data %b expected 1 1",
                     o_ps2_clk, o_ps2_data); end
        repeat (2) @(negedge clk);
        i_sclr = 1'b0;
        @(negedge clk);
        checks++; if (o_key_ready !== 1'b1 || o_busy !== 1'b0) begin errors++;
            $display("FAIL rst_mid_ready: got ready %b busy %b expected 1 0",
                     o_key_ready, o_busy); end
        clear_mon();
        repeat (3 * SLOT) @(negedge clk);
        checks++; if (fall_cyc.size() != 0 || low_cycles != 0 || en_cyc.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: got %0d falls %0d low %0d byte_en expected 0 0 0",
                     fall_cyc.size(), low_cycles, en_cyc.size());
        end
        checks++; if (o_key_ready !== 1'b1 || o_ps2_data !== 1'b1) begin errors++;
            $display("FAIL rst_mid_idle: got ready %b data %b expected 1 1",
                     o_key_ready, o_ps2_data); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            test_key_event(8'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        i_sclr      = 1'b1;
        i_key_valid = 1'b0;
        i_key_code  = 8'h00;
        i_key_break = 1'b0;
        i_key_ext   = 1'b0;
        test_reset();
        test_key_event(8'h1C, 1'b0, 1'b0);
        test_key_event(8'h1C, 1'b1, 1'b0);
        test_key_event(8'h74, 1'b1, 1'b1);
        test_back_to_back();
        test_reset_mid_frame();
        test_key_event(8'h00, 1'b0, 1'b0);
        test_key_event(8'hFF, 1'b0, 1'b0);
        test_key_event(8'hF0, 1'b0, 1'b1);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
